sdram_arbiter: RTL

Shares the single-ported SDRAM controller command interface among NPORTS requesters, e.g. the SPI debug bridge, a video fetcher and a DMA engine. It round-robins between pending requests and latches the winning command. It drives the controller's req/addr/rh_wl/data_w and holds them until the controller acks. Read data returned by the controller is steered back to the granted requester. The block sits between the requesters and the SDRAM controller, in the same clock domain.

---
 rtl/sdram_arb_pkg.sv | 27 ++
 rtl/sdram_arbiter_rr_pick.sv | 34 +++
 rtl/sdram_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and helpers for the SDRAM command arbiter.
//   state_t      - arbiter FSM states
//   DEF_AW/DEF_DW - default SDRAM word-address and data widths
//   clog2()      - index width for a requester count (minimum 1 bit)
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int unsigned DEF_AW = 24;
   localparam int unsigned DEF_DW = 16;

   // Bits needed to index n items; never returns less than 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req     in  N   request vector
//   ptr     in  IW  highest-priority index (must be < N)
//   grant_c out IW  first set request found scanning ptr, ptr+1, ... mod N
//   valid_c out 1   at least one request set
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant_c,
   output logic          valid_c
);

   logic [IW-1:0] idx;

   // Scan from the far end back toward ptr so the nearest request wins last.
   always_comb begin
      grant_c = '0;
      valid_c = 1'b0;
      idx     = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         idx = IW'((int'(ptr) + i) % int'(N));
         if (req[idx]) begin
            grant_c = idx;
            valid_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM controller command port
// among NPORTS requesters. One controller transaction outstanding at a time.
// Optional macro SDRAM_ARB_TIMEOUT_EN: abort a read after RD_TIMEOUT cycles
// in WAIT_RD, completing with p_err and zero read data.
//   clk, reset       clock, synchronous active-high reset
//   p_req/p_addr/p_rh_wl/p_data_w   per-port command (port i at [i*W +: W])
//   p_ack/p_err      one-hot completion / timeout pulse
//   p_data_r         read data of the last completed read
//   sdram_req/addr/rh_wl/data_w     latched command to controller
//   sdram_ack, sdram_data_r, sdram_data_r_en   controller responses
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned NPORTS     = 4,
   parameter int unsigned AW         = DEF_AW,
   parameter int unsigned DW         = DEF_DW,
   parameter int unsigned RD_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NPORTS-1:0]    p_req,
   input  logic [NPORTS*AW-1:0] p_addr,
   input  logic [NPORTS-1:0]    p_rh_wl,
   input  logic [NPORTS*DW-1:0] p_data_w,
   output logic [NPORTS-1:0]    p_ack,
   output logic [NPORTS-1:0]    p_err,
   output logic [DW-1:0]        p_data_r,
   output logic                 sdram_req,
   output logic [AW-1:0]        sdram_addr,
   output logic                 sdram_rh_wl,
   output logic [DW-1:0]        sdram_data_w,
   input  logic                 sdram_ack,
   input  logic [DW-1:0]        sdram_data_r,
   input  logic                 sdram_data_r_en
);

   localparam int unsigned IW = clog2(NPORTS);

   // Elaboration-time parameter sanity check.
   if (NPORTS < 2 || NPORTS > 8 || RD_TIMEOUT < 2) begin : g_bad_param
      $error("sdram_arbiter: NPORTS must be 2..8 and RD_TIMEOUT >= 2");
   end

   state_t              state, state_n;
   logic [IW-1:0]       ptr, ptr_n;
   logic [IW-1:0]       gnt, gnt_n;
   logic                req_n;
   logic [AW-1:0]       addr_n;
   logic                rh_wl_n;
   logic [DW-1:0]       data_w_n;
   logic [NPORTS-1:0]   ack_n;
   logic [DW-1:0]       data_r_n;

   logic [IW-1:0]       pick_c;
   logic                pick_valid_c;
   logic [AW-1:0]       sel_addr_c;
   logic                sel_rh_wl_c;
   logic [DW-1:0]       sel_data_w_c;

   rr_pick #(.N(NPORTS), .IW(IW)) u_pick (
      .req     (p_req),
      .ptr     (ptr),
      .grant_c (pick_c),
      .valid_c (pick_valid_c)
   );

   // Mux the winning port's command fields.
   always_comb begin
      sel_addr_c   = '0;
      sel_rh_wl_c  = 1'b1;
      sel_data_w_c = '0;
      for (int i = 0; i < int'(NPORTS); i++) begin
         if (pick_c == IW'(i)) begin
            sel_addr_c   = p_addr[i*AW +: AW];
            sel_rh_wl_c  = p_rh_wl[i];
            sel_data_w_c = p_data_w[i*DW +: DW];
         end
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int unsigned CW = clog2(RD_TIMEOUT);
   logic [CW-1:0]       cnt, cnt_n;
   logic [NPORTS-1:0]   err_n;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      gnt_n    = gnt;
      req_n    = sdram_req;
      addr_n   = sdram_addr;
      rh_wl_n  = sdram_rh_wl;
      data_w_n = sdram_data_w;
      ack_n    = '0;
      data_r_n = p_data_r;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_n    = cnt;
      err_n    = '0;
`endif
      case (state)
         IDLE: begin
            if (pick_valid_c) begin
               gnt_n    = pick_c;
               addr_n   = sel_addr_c;
               rh_wl_n  = sel_rh_wl_c;
               data_w_n = sel_data_w_c;
               req_n    = 1'b1;
               state_n  = ISSUE;
            end
         end
         ISSUE: begin
            if (sdram_ack) begin
               req_n = 1'b0;
               if (!sdram_rh_wl) begin
                  ack_n   = NPORTS'(1) << gnt;
                  state_n = DONE;
               end else if (sdram_data_r_en) begin
                  // Controller returned data in the same cycle as the accept.
                  data_r_n = sdram_data_r;
                  ack_n    = NPORTS'(1) << gnt;
                  state_n  = DONE;
               end else begin
                  state_n = WAIT_RD;
`ifdef SDRAM_ARB_TIMEOUT_EN
                  cnt_n   = '0;
`endif
               end
            end
         end
         WAIT_RD: begin
            if (sdram_data_r_en) begin
               data_r_n = sdram_data_r;
               ack_n    = NPORTS'(1) << gnt;
               state_n  = DONE;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            // Data arriving on the timeout cycle takes precedence above.
            else if (cnt == CW'(RD_TIMEOUT - 1)) begin
               data_r_n = '0;
               ack_n    = NPORTS'(1) << gnt;
               err_n    = NPORTS'(1) << gnt;
               state_n  = DONE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
`endif
         end
         DONE: begin
            ptr_n   = (gnt == IW'(NPORTS - 1)) ? '0 : gnt + IW'(1);
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ptr          <= '0;
         gnt          <= '0;
         sdram_req    <= 1'b0;
         sdram_addr   <= '0;
         sdram_rh_wl  <= 1'b1;
         sdram_data_w <= '0;
         p_ack        <= '0;
         p_data_r     <= '0;
      end else begin
         state        <= state_n;
         ptr          <= ptr_n;
         gnt          <= gnt_n;
         sdram_req    <= req_n;
         sdram_addr   <= addr_n;
         sdram_rh_wl  <= rh_wl_n;
         sdram_data_w <= data_w_n;
         p_ack        <= ack_n;
         p_data_r     <= data_r_n;
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   // Read-timeout counter and error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         p_err <= '0;
      end else begin
         cnt   <= cnt_n;
         p_err <= err_n;
      end
   end
`else
   assign p_err = '0;
`endif

endmodule
